boot_image_loader: RTL and testbench

BOOT_IMAGE_LOADER -- requirements
Module: boot_image_loader

---
 rtl/loader_pkg.sv | 33 +++
 rtl/byte_word_packer.sv | 50 +++++
 rtl/boot_image_loader.sv | 152 +++++++++++++++
 tb/tb_boot_image_loader.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding and frame constants for the boot image loader
//
// Purpose : state enum, default frame start byte and memory target codes
//           shared by boot_image_loader and its bench.
// Ports   : none (package).

package loader_pkg;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;
  localparam logic [7:0] TARGET_INST   = 8'h00;
  localparam logic [7:0] TARGET_DATA   = 8'h01;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ARMED,
    ST_TARGET,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } load_state_e;

  // States in which the loader is willing to take a byte.
  function automatic logic is_receive_state(input load_state_e s);
    return (s != ST_IDLE) && (s != ST_DONE) && (s != ST_ERROR);
  endfunction

endpackage

// File: rtl/byte_word_packer.sv
// rtl/byte_word_packer.sv - big-endian word assembly and running XOR checksum
//
// Purpose : holds the high payload byte until the low byte arrives and
//           presents the assembled word; XORs every payload byte into a
//           running checksum.
// Ports   : clk, rst (async, active-high), clr (sync clear), en (clock enable),
//           hi_load / lo_load (payload byte accepted as high / low half),
//           byte_data (incoming byte), word ({held high, byte_data}),
//           checksum (XOR of all payload bytes so far).

module byte_word_packer #(
  parameter int DATABITWIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    hi_load,
  input  logic                    lo_load,
  input  logic [7:0]              byte_data,
  output logic [DATABITWIDTH-1:0] word,
  output logic [7:0]              checksum
);

  logic [7:0] hi_q;
  logic [7:0] chk_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q  <= 8'h00;
      chk_q <= 8'h00;
    end else if (clr) begin
      hi_q  <= 8'h00;
      chk_q <= 8'h00;
    end else if (en) begin
      if (hi_load) begin
        hi_q <= byte_data;
      end
      if (hi_load || lo_load) begin
        chk_q <= chk_q ^ byte_data;
      end
    end
  end

  // Combinational so the top can register the full word on the same edge
  // that accepts the low byte.
  assign word     = DATABITWIDTH'({hi_q, byte_data});
  assign checksum = chk_q;

endmodule

// File: rtl/boot_image_loader.sv
// rtl/boot_image_loader.sv - serial boot frame parser writing instruction/data memory
//
// Purpose : parses MAGIC, TARGET, CNT(2), ADDR(2), CNT words (2 bytes each),
//           CHECK from a byte stream and emits registered memory write strobes.
// Ports   : clk, async_rst, clk_en, sync_rst; LoadStart arms the loader;
//           ByteValid/ByteData/ByteReady byte handshake; InstFlashEn,
//           DataFlashEn, FlashAddr, FlashData write port; SystemEnable when
//           the image verified; LoadError sticky on bad target or checksum.

module boot_image_loader
  import loader_pkg::*;
#(
  parameter int         DATABITWIDTH = 16,
  parameter int         ADDRBITWIDTH = 16,
  parameter logic [7:0] MAGIC        = MAGIC_DEFAULT
) (
  input  logic                    clk,
  input  logic                    async_rst,
  input  logic                    clk_en,
  input  logic                    sync_rst,
  input  logic                    LoadStart,
  input  logic                    ByteValid,
  input  logic [7:0]              ByteData,
  output logic                    ByteReady,
  output logic                    InstFlashEn,
  output logic                    DataFlashEn,
  output logic [ADDRBITWIDTH-1:0] FlashAddr,
  output logic [DATABITWIDTH-1:0] FlashData,
  output logic                    SystemEnable,
  output logic                    LoadError
);

  load_state_e             state_q;
  load_state_e             state_d;
  logic                    accept;
  logic                    is_data_q;
  logic [7:0]              cnt_hi_q;
  logic [15:0]             count_q;
  logic [7:0]              addr_hi_q;
  logic [ADDRBITWIDTH-1:0] addr_q;
  logic [DATABITWIDTH-1:0] packed_word;
  logic [7:0]              checksum;

  assign accept = ByteValid && ByteReady && clk_en;

  byte_word_packer #(
    .DATABITWIDTH(DATABITWIDTH)
  ) u_packer (
    .clk      (clk),
    .rst      (async_rst),
    .clr      (sync_rst),
    .en       (clk_en),
    .hi_load  (accept && (state_q == ST_DATA_HI)),
    .lo_load  (accept && (state_q == ST_DATA_LO)),
    .byte_data(ByteData),
    .word     (packed_word),
    .checksum (checksum)
  );

  // State register
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state_q <= ST_IDLE;
    end else if (sync_rst) begin
      state_q <= ST_IDLE;
    end else if (clk_en) begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (LoadStart) state_d = ST_ARMED;
      ST_ARMED:   if (accept && (ByteData == MAGIC)) state_d = ST_TARGET;
      ST_TARGET: begin
        if (accept) begin
          if ((ByteData == TARGET_INST) || (ByteData == TARGET_DATA)) begin
            state_d = ST_CNT_HI;
          end else begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_CNT_HI:  if (accept) state_d = ST_CNT_LO;
      ST_CNT_LO:  if (accept) state_d = ST_ADDR_HI;
      ST_ADDR_HI: if (accept) state_d = ST_ADDR_LO;
      // count_q was loaded two bytes earlier, so it is already valid here.
      ST_ADDR_LO: if (accept) state_d = (count_q == 16'd0) ? ST_CHECK : ST_DATA_HI;
      ST_DATA_HI: if (accept) state_d = ST_DATA_LO;
      // count_q still includes the word being written on this edge.
      ST_DATA_LO: if (accept) state_d = (count_q == 16'd1) ? ST_CHECK : ST_DATA_HI;
      ST_CHECK:   if (accept) state_d = (ByteData == checksum) ? ST_DONE : ST_ERROR;
      default:    state_d = state_q;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    ByteReady    = is_receive_state(state_q);
    SystemEnable = (state_q == ST_DONE);
    LoadError    = (state_q == ST_ERROR);
  end

  // Frame fields and registered write port
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      is_data_q   <= 1'b0;
      cnt_hi_q    <= 8'h00;
      count_q     <= 16'd0;
      addr_hi_q   <= 8'h00;
      addr_q      <= '0;
      InstFlashEn <= 1'b0;
      DataFlashEn <= 1'b0;
      FlashAddr   <= '0;
      FlashData   <= '0;
    end else if (sync_rst) begin
      is_data_q   <= 1'b0;
      cnt_hi_q    <= 8'h00;
      count_q     <= 16'd0;
      addr_hi_q   <= 8'h00;
      addr_q      <= '0;
      InstFlashEn <= 1'b0;
      DataFlashEn <= 1'b0;
      FlashAddr   <= '0;
      FlashData   <= '0;
    end else if (clk_en) begin
      InstFlashEn <= 1'b0;
      DataFlashEn <= 1'b0;
      if (accept) begin
        case (state_q)
          ST_TARGET:  is_data_q <= (ByteData == TARGET_DATA);
          ST_CNT_HI:  cnt_hi_q  <= ByteData;
          ST_CNT_LO:  count_q   <= {cnt_hi_q, ByteData};
          ST_ADDR_HI: addr_hi_q <= ByteData;
          ST_ADDR_LO: addr_q    <= ADDRBITWIDTH'({addr_hi_q, ByteData});
          ST_DATA_LO: begin
            InstFlashEn <= !is_data_q;
            DataFlashEn <= is_data_q;
            FlashAddr   <= addr_q;
            FlashData   <= packed_word;
            addr_q      <= addr_q + ADDRBITWIDTH'(1);
            count_q     <= count_q - 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_boot_image_loader.sv
// tb/tb_boot_image_loader.sv - scoreboard bench for boot_image_loader

module tb_boot_image_loader;

  logic        clk = 1'b0;
  logic        async_rst;
  logic        clk_en;
  logic        sync_rst;
  logic        LoadStart;
  logic        ByteValid;
  logic [7:0]  ByteData;
  logic        ByteReady;
  logic        InstFlashEn;
  logic        DataFlashEn;
  logic [15:0] FlashAddr;
  logic [15:0] FlashData;
  logic        SystemEnable;
  logic        LoadError;

  always #5 clk = ~clk;

  boot_image_loader dut (
    .clk         (clk),
    .async_rst   (async_rst),
    .clk_en      (clk_en),
    .sync_rst    (sync_rst),
    .LoadStart   (LoadStart),
    .ByteValid   (ByteValid),
    .ByteData    (ByteData),
    .ByteReady   (ByteReady),
    .InstFlashEn (InstFlashEn),
    .DataFlashEn (DataFlashEn),
    .FlashAddr   (FlashAddr),
    .FlashData   (FlashData),
    .SystemEnable(SystemEnable),
    .LoadError   (LoadError)
  );

  typedef struct {
    logic        is_data;
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  gap_max = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!async_rst && (InstFlashEn || DataFlashEn)) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe: got inst=%b data=%b addr=%h data=%h expected none",
                 InstFlashEn, DataFlashEn, FlashAddr, FlashData);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("strobe_exclusive", {31'd0, InstFlashEn & DataFlashEn}, 32'd0);
        chk("strobe_target", {31'd0, DataFlashEn}, {31'd0, e.is_data});
        chk("flash_addr", {16'd0, FlashAddr}, {16'd0, e.addr});
        chk("flash_data", {16'd0, FlashData}, {16'd0, e.data});
      end
    end
  end

  task automatic do_reset(input logic use_sync);
    @(negedge clk);
    if (use_sync) sync_rst = 1'b1;
    else          async_rst = 1'b1;
    repeat (2) @(negedge clk);
    sync_rst  = 1'b0;
    async_rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_load();
    LoadStart = 1'b1;
    @(negedge clk);
    LoadStart = 1'b0;
  endtask

  // Offer one byte; returns at the negedge after it was accepted.
  task automatic send_byte(input logic [7:0] b, input logic pause);
    logic acc;
    acc = 1'b0;
    repeat ($urandom_range(0, gap_max)) @(negedge clk);
    ByteValid = 1'b1;
    ByteData  = b;
    if (pause) begin
      clk_en = 1'b0;
      for (int p = 0; p < 5; p++) begin
        @(negedge clk);
        chk("pause_ready", {31'd0, ByteReady}, 32'd1);
        chk("pause_no_strobe", {30'd0, InstFlashEn, DataFlashEn}, 32'd0);
      end
      clk_en = 1'b1;
    end
    for (int t = 0; t < 20; t++) begin
      acc = ByteReady && clk_en;
      @(negedge clk);
      if (acc) break;
    end
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL byte_timeout: byte %h not accepted within 20 cycles", b);
    end
    ByteValid = 1'b0;
  endtask

  // Reference model: a frame is a list of fields; the writes it must cause
  // and its outcome follow directly from those fields.
  task automatic run_frame(input logic [7:0] garbage[$], input logic [7:0] target,
                           input logic [15:0] addr, input logic [15:0] words[$],
                           input logic bad_chk, input int pause_word,
                           input logic extra_start);
    logic [7:0]  x;
    logic [7:0]  ck;
    logic [15:0] cnt;
    wr_t         w;
    cnt = 16'(words.size());
    start_load();
    foreach (garbage[i]) send_byte(garbage[i], 1'b0);
    send_byte(8'hA5, 1'b0);
    send_byte(target, 1'b0);
    if (target > 8'h01) begin
      repeat (2) @(negedge clk);
      chk("bad_target_error", {31'd0, LoadError}, 32'd1);
      chk("bad_target_ready", {31'd0, ByteReady}, 32'd0);
      chk("bad_target_sysen", {31'd0, SystemEnable}, 32'd0);
      return;
    end
    if (extra_start) LoadStart = 1'b1;
    send_byte(cnt[15:8], 1'b0);
    LoadStart = 1'b0;
    send_byte(cnt[7:0], 1'b0);
    send_byte(addr[15:8], 1'b0);
    send_byte(addr[7:0], 1'b0);
    x = 8'h00;
    foreach (words[i]) begin
      w.is_data = (target == 8'h01);
      w.addr    = 16'(addr + 16'(i));
      w.data    = words[i];
      exp_q.push_back(w);
      x = x ^ words[i][15:8] ^ words[i][7:0];
      send_byte(words[i][15:8], 1'b0);
      send_byte(words[i][7:0], i == pause_word);
    end
    ck = bad_chk ? (x ^ 8'($urandom_range(1, 255))) : x;
    send_byte(ck, 1'b0);
    repeat (2) @(negedge clk);
    chk("end_sysen", {31'd0, SystemEnable}, {31'd0, !bad_chk});
    chk("end_error", {31'd0, LoadError}, {31'd0, bad_chk});
    chk("end_ready", {31'd0, ByteReady}, 32'd0);
    chk("all_writes_seen", exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [7:0]  g[$];
    logic [7:0]  gnone[$];
    logic [15:0] ws[$];
    logic [7:0]  tgt;
    logic [15:0] a;
    int          n;

    async_rst = 1'b1;
    sync_rst  = 1'b0;
    clk_en    = 1'b1;
    LoadStart = 1'b0;
    ByteValid = 1'b0;
    ByteData  = 8'h00;
    gnone     = {};
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, ByteReady}, 32'd0);
    chk("rst_strobes", {30'd0, InstFlashEn, DataFlashEn}, 32'd0);
    chk("rst_addr", {16'd0, FlashAddr}, 32'd0);
    chk("rst_data", {16'd0, FlashData}, 32'd0);
    chk("rst_sysen", {31'd0, SystemEnable}, 32'd0);
    chk("rst_error", {31'd0, LoadError}, 32'd0);
    async_rst = 1'b0;
    @(negedge clk);

    // Two-word instruction frame
    ws = {16'h1234, 16'h5678};
    run_frame(gnone, 8'h00, 16'h0010, ws, 1'b0, -1, 1'b0);

    // Data frame at top of memory, then a two-word wrap
    do_reset(1'b0);
    ws = {16'hABCD};
    run_frame(gnone, 8'h01, 16'hFFFF, ws, 1'b0, -1, 1'b0);
    do_reset(1'b0);
    ws = {16'h0102, 16'h0304};
    run_frame(gnone, 8'h01, 16'hFFFF, ws, 1'b0, -1, 1'b0);

    // Garbage ahead of MAGIC, zero-count frame
    do_reset(1'b1);
    g  = {8'h3C, 8'h11};
    ws = {};
    run_frame(g, 8'h00, 16'h0000, ws, 1'b0, -1, 1'b0);

    // Illegal target
    do_reset(1'b0);
    ws = {16'h1234};
    run_frame(gnone, 8'h02, 16'h0000, ws, 1'b0, -1, 1'b0);

    // Wrong checksum
    do_reset(1'b0);
    ws = {16'h1234, 16'h5678};
    run_frame(gnone, 8'h00, 16'h0010, ws, 1'b1, -1, 1'b0);

    // Clock-enable pause between the halves of a word, plus ignored LoadStart
    do_reset(1'b1);
    ws = {16'hCAFE, 16'h0BAD, 16'h7777};
    run_frame(gnone, 8'h01, 16'h0200, ws, 1'b0, 1, 1'b1);

    // Asynchronous reset right after the first word's strobe is registered
    do_reset(1'b0);
    start_load();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h40, 1'b0);
    begin
      wr_t w;
      w.is_data = 1'b0;
      w.addr    = 16'h0040;
      w.data    = 16'hBEEF;
      exp_q.push_back(w);
    end
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b0);
    #2 async_rst = 1'b1;
    #1;
    chk("arst_strobe_cleared", {30'd0, InstFlashEn, DataFlashEn}, 32'd0);
    chk("arst_addr_cleared", {16'd0, FlashAddr}, 32'd0);
    chk("arst_ready_idle", {31'd0, ByteReady}, 32'd0);
    @(negedge clk);
    async_rst = 1'b0;
    ByteValid = 1'b1;
    ByteData  = 8'h12;
    repeat (4) @(negedge clk);
    ByteValid = 1'b0;
    chk("arst_stays_idle", {31'd0, ByteReady}, 32'd0);
    chk("arst_sysen", {31'd0, SystemEnable}, 32'd0);
    chk("arst_writes_seen", exp_q.size(), 32'd0);

    // Randomized frames
    gap_max = 2;
    for (int f = 0; f < 25; f++) begin
      do_reset(f[0]);
      g = {};
      n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) begin
        logic [7:0] gb;
        gb = 8'($urandom_range(0, 255));
        if (gb == 8'hA5) gb = 8'h5A;
        g.push_back(gb);
      end
      tgt = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(2, 255)) : 8'($urandom_range(0, 1));
      a   = $urandom_range(0, 1) ? 16'($urandom_range(0, 65535)) : 16'(16'hFFFF - 16'($urandom_range(0, 3)));
      ws  = {};
      n   = $urandom_range(0, 4);
      for (int i = 0; i < n; i++) ws.push_back(16'($urandom_range(0, 65535)));
      run_frame(g, tgt, a, ws, $urandom_range(0, 4) == 0,
                (n > 0) ? int'($urandom_range(0, n - 1)) : -1,
                1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
